video_pixel_out: RTL
====================

Name: video_pixel_out

Overview:
- Back-end stage directly downstream of the VRAM fetch/sequencer block.
- Consumes the per-phase strobes, the raw VRAM data word and the per-character mode flags that the fetch block produces, and serialises them into a 24-bit RGB pixel stream with blanking, border colour and H/V sync.
- Runs on the 42 MHz video clock and feeds the DAC/scan-doubler.

Parameters:
- HS_START, 50, cntx value at which hsync_o asserts.
- HS_END, 53, last cntx value with hsync_o asserted.
- VS_START, 304, cnty value at which vsync_o asserts.
- VS_END, 307, last cnty value with vsync_o asserted.
- BRD_LEVEL, 8'hC0, 8-bit intensity of a set border colour bit.

Ports:
- clk42_i  in  1  video clock, 42 MHz; the only clock.
- res_i  in  1  reset, synchronous, active-high.
- vram_dat_i  in  32  VRAM data bus; [23:0] is the palette RGB when pal_stb_i=1.
- pal_stb_i  in  1  palette word valid on vram_dat_i this cycle.
- pal_sel_i  in  1  text mode: 0 = paper colour, 1 = ink colour; ignored in gfx mode.
- pix_byte_i  in  8  text-mode pixel byte.
- pix_load_i  in  1  character boundary: load pix_byte_i and sample mode flags.
- pix_ce_i  in  1  pixel clock enable, 14 MHz rate.
- text_mode_i  in  1  1 = text (ink/paper) mode, 0 = graphics mode.
- bord_i  in  1  border region.
- blank_i  in  1  blanking.
- brd_i  in  3  border colour: bit0 B, bit1 R, bit2 G.
- cntx_i  in  6  character column counter.
- cnty_i  in  9  line counter.
- clr_err_i  in  1  clears the sticky error flags.
- rgb_o  out  24  {R,G,B} 8 bits each.
- hsync_o  out  1  horizontal sync, active-high.
- vsync_o  out  1  vertical sync, active-high.
- de_o  out  1  active-display enable.
- ovf_o  out  1  sticky: colour FIFO overflow.
- unf_o  out  1  sticky: colour FIFO underflow.

Behaviour:
Reset
- While res_i=1 at a clock edge, all of the following are cleared to 0: rgb_o, hsync_o, vsync_o, de_o, ovf_o, unf_o, shift register, ink/paper registers, FIFO count/pointers, sampled mode flags and last colour.
- Reset mid-line discards any FIFO contents. Output resumes at the first pix_ce_i after res_i deasserts.

Mode sampling
- text_mode_i, bord_i, blank_i and brd_i are registered only on cycles with pix_load_i=1. They hold until the next pix_load_i.

Text mode
- pal_stb_i writes vram_dat_i[23:0] to the ink register (pal_sel_i=1) or the paper register (pal_sel_i=0).
- pix_load_i loads pix_byte_i into an 8-bit shift register.
- Each pix_ce_i selects ink if shreg[7]=1, else paper, then shifts left and fills with 0.
- If pix_load_i and pix_ce_i occur in the same cycle, the load wins and the new byte's bit7 is used for that pixel.

Graphics mode
- pal_stb_i pushes vram_dat_i[23:0] into a 2-entry colour FIFO. pix_ce_i pops one entry per pixel.
- Push when full (no pop in the same cycle): the push is dropped and ovf_o is set.
- Pop when empty: the last popped colour is repeated and unf_o is set.
- Push and pop in the same cycle: both occur; the count is unchanged. This also applies when full. When empty, the pushed word passes straight through to the output.

Output selection, registered on pix_ce_i, priority order
- blank → 0.
- bord → {brd[1]?BRD_LEVEL:0, brd[2]?BRD_LEVEL:0, brd[0]?BRD_LEVEL:0}.
- Otherwise the text or gfx colour.
- de_o = !blank && !bord, sampled with the same pixel.

Latency
- rgb_o and de_o update 1 clock after pix_ce_i. They hold between pix_ce_i pulses.

Sync
- hsync_o = (HS_START <= cntx_i <= HS_END); vsync_o = (VS_START <= cnty_i <= VS_END).
- Both are registered every clock (1-cycle latency) and are independent of pix_ce_i.

Error flags
- ovf_o and unf_o stay set until clr_err_i or res_i. If clr_err_i coincides with a new error event, the flag stays set.

Decomposition:
- Shared package video_pkg holds:
  - RGB width constant (24).
  - Border-colour bit mapping localparams.
  - A typedef struct for the sampled mode flags {text, bord, blank, brd}, shared with the fetch block.
- One sub-module, video_color_fifo: the 2-entry FIFO with push/pop, full/empty and the ovf/unf pulse outputs.
- Sync comparators and the shifter stay in the top level.

Test Plan:
1. Text mode: paper=24'h0000FF, ink=24'hFF0000, pix_byte=8'hA5, then 8 pix_ce → rgb_o sequence ink,paper,ink,paper,paper,ink,paper,ink, each 1 clk after its pix_ce.
2. Gfx mode: push 24'h111111, then 24'h222222, then 2 pops → 111111 then 222222; a third push while full and not popping → ovf_o=1 and FIFO contents unchanged.
3. Gfx mode, pop on empty after last colour 24'h222222 → rgb_o=222222 and unf_o=1; clr_err_i pulse → unf_o=0 the next clk.
4. Border: pix_load with bord_i=1, brd_i=3'b011, then pix_ce → rgb_o=24'hC000C0 and de_o=0. With blank_i=1 also set → rgb_o=0.
5. Sync: sweep cntx_i 49..54 → hsync_o high exactly for 50..53 (1-clk delayed). Sweep cnty_i 303..308 → vsync_o high for 304..307.
6. Reset mid-line with the FIFO holding 2 entries and rgb_o non-zero: res_i=1 for 1 clk → all outputs 0. The next pix_ce with no push gives rgb_o=0 and unf_o=1.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the video back end: colour widths, border bit mapping
// and the per-character mode flags exchanged with the VRAM fetch block.
package video_pkg;

    localparam int RGB_W = 24;

    localparam int BRD_B = 0;
    localparam int BRD_R = 1;
    localparam int BRD_G = 2;

    typedef struct packed {
        logic       text;
        logic       bord;
        logic       blank;
        logic [2:0] brd;
    } mode_t;

endpackage

// File: rtl/video_color_fifo.sv
// Two-entry colour FIFO for graphics mode; pop on empty repeats the last colour,
// or passes a same-cycle push straight through.
module video_color_fifo
    import video_pkg::*;
(
    input  logic             clk_i,
    input  logic             res_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [RGB_W-1:0] dat_i,
    output logic [RGB_W-1:0] dat_o,
    output logic             ovf_o,
    output logic             unf_o
);

    logic [RGB_W-1:0] mem_q [2];
    logic [RGB_W-1:0] last_q;
    logic             wr_q, rd_q;
    logic [1:0]       cnt_q, cnt_d;
    logic             empty, full, pop_mem, thru, wr_en;

    always_comb begin
        empty   = (cnt_q == 2'd0);
        full    = (cnt_q == 2'd2);
        pop_mem = pop_i && !empty;
        thru    = pop_i && empty && push_i;
        // When full, a simultaneous pop frees the slot being written (wr == rd).
        wr_en   = push_i && !thru && (!full || pop_i);
        dat_o   = !empty ? mem_q[rd_q] : (push_i ? dat_i : last_q);
        ovf_o   = push_i && full && !pop_i;
        unf_o   = pop_i && empty && !push_i;
        cnt_d   = cnt_q;
        if (wr_en && !pop_mem) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!wr_en && pop_mem) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            cnt_q  <= 2'd0;
            last_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (wr_en)   wr_q   <= ~wr_q;
            if (pop_mem) rd_q   <= ~rd_q;
            if (pop_i)   last_q <= dat_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !res_i) mem_q[wr_q] <= dat_i;
    end

endmodule

// File: rtl/video_pixel_out.sv
// Pixel back end: serialises text/graphics colours into registered RGB with
// border, blanking, sync and sticky FIFO error flags.
module video_pixel_out
    import video_pkg::*;
#(
    parameter logic [5:0] HS_START  = 6'd50,
    parameter logic [5:0] HS_END    = 6'd53,
    parameter logic [8:0] VS_START  = 9'd304,
    parameter logic [8:0] VS_END    = 9'd307,
    parameter logic [7:0] BRD_LEVEL = 8'hC0
) (
    input  logic        clk42_i,
    input  logic        res_i,
    input  logic [31:0] vram_dat_i,
    input  logic        pal_stb_i,
    input  logic        pal_sel_i,
    input  logic [7:0]  pix_byte_i,
    input  logic        pix_load_i,
    input  logic        pix_ce_i,
    input  logic        text_mode_i,
    input  logic        bord_i,
    input  logic        blank_i,
    input  logic [2:0]  brd_i,
    input  logic [5:0]  cntx_i,
    input  logic [8:0]  cnty_i,
    input  logic        clr_err_i,
    output logic [23:0] rgb_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic        ovf_o,
    output logic        unf_o
);

    mode_t            mode_q, mode_cur;
    logic [7:0]       shreg_q, shreg_cur;
    logic [RGB_W-1:0] ink_q, paper_q, rgb_q, pix_rgb, fifo_dat;
    logic             de_q, hs_q, vs_q, ovf_q, unf_q;
    logic             fifo_push, fifo_pop, ovf_evt, unf_evt;

    function automatic logic [RGB_W-1:0] brd_color(input logic [2:0] b);
        return {b[BRD_R] ? BRD_LEVEL : 8'h00,
                b[BRD_G] ? BRD_LEVEL : 8'h00,
                b[BRD_B] ? BRD_LEVEL : 8'h00};
    endfunction

    // A load in the same cycle as a pixel strobe takes effect for that pixel.
    always_comb begin
        mode_cur = mode_q;
        if (pix_load_i) begin
            mode_cur.text  = text_mode_i;
            mode_cur.bord  = bord_i;
            mode_cur.blank = blank_i;
            mode_cur.brd   = brd_i;
        end
        shreg_cur = pix_load_i ? pix_byte_i : shreg_q;
        fifo_push = pal_stb_i && !mode_cur.text;
        fifo_pop  = pix_ce_i && !mode_cur.text;
        if (mode_cur.blank)     pix_rgb = '0;
        else if (mode_cur.bord) pix_rgb = brd_color(mode_cur.brd);
        else if (mode_cur.text) pix_rgb = shreg_cur[7] ? ink_q : paper_q;
        else                    pix_rgb = fifo_dat;
    end

    video_color_fifo u_fifo (
        .clk_i  (clk42_i),
        .res_i  (res_i),
        .push_i (fifo_push),
        .pop_i  (fifo_pop),
        .dat_i  (vram_dat_i[RGB_W-1:0]),
        .dat_o  (fifo_dat),
        .ovf_o  (ovf_evt),
        .unf_o  (unf_evt)
    );

    always_ff @(posedge clk42_i) begin
        if (res_i) begin
            mode_q  <= '0;
            shreg_q <= '0;
            ink_q   <= '0;
            paper_q <= '0;
            rgb_q   <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            mode_q <= mode_cur;
            if (pix_ce_i)        shreg_q <= {shreg_cur[6:0], 1'b0};
            else if (pix_load_i) shreg_q <= pix_byte_i;
            if (pal_stb_i && mode_cur.text) begin
                if (pal_sel_i) ink_q   <= vram_dat_i[RGB_W-1:0];
                else           paper_q <= vram_dat_i[RGB_W-1:0];
            end
            if (pix_ce_i) begin
                rgb_q <= pix_rgb;
                de_q  <= !mode_cur.blank && !mode_cur.bord;
            end
            hs_q  <= (cntx_i >= HS_START) && (cntx_i <= HS_END);
            vs_q  <= (cnty_i >= VS_START) && (cnty_i <= VS_END);
            ovf_q <= (ovf_q && !clr_err_i) || ovf_evt;
            unf_q <= (unf_q && !clr_err_i) || unf_evt;
        end
    end

    assign rgb_o   = rgb_q;
    assign de_o    = de_q;
    assign hsync_o = hs_q;
    assign vsync_o = vs_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule
